// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: accepts header/data words, then drives FrameData and a one-hot
// FrameStrobe with setup/strobe/hold timing for level-sensitive tile config latches.
`timescale 1ns/1ps

module frame_config_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [31:0]                           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  output logic [15:0]                           frames_done
);

  localparam int NUM_STROBES = NumColumns * MaxFramesPerCol;
  localparam int COL_W       = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int FRAME_W     = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int IDX_W       = (NUM_STROBES > 1) ? $clog2(NUM_STROBES) : 1;
  localparam int CNT_W       = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(MaxFramesPerCol - 1);
  localparam logic [CNT_W-1:0]   LAST_STROBE = CNT_W'(StrobeCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COL_W-1:0]           r_col;
  logic [FRAME_W-1:0]         r_frame;
  logic                       r_burst;
  logic [CNT_W-1:0]           r_cnt;
  logic [FrameBitsPerRow-1:0] r_frame_data;
  logic [NUM_STROBES-1:0]     r_strobe;
  logic                       r_ready;
  logic                       r_err;
  logic [15:0]                r_frames_done;

  logic [7:0]             w_hdr_col;
  logic [7:0]             w_hdr_frame;
  logic                   w_hdr_ok;
  logic                   w_accept;
  logic                   w_load_hdr;
  logic                   w_load_data;
  logic                   w_hdr_err;
  logic                   w_strobe_done;
  logic                   w_advance;
  logic [IDX_W-1:0]       w_strobe_idx;
  logic [NUM_STROBES-1:0] w_strobe_next;
  logic                   w_unused;

  // Header fields that carry no meaning are folded here so they are visibly ignored.
  assign w_unused    = &{1'b0, s_data[29:24], s_data[15:8]};
  assign w_hdr_col   = s_data[23:16];
  assign w_hdr_frame = s_data[7:0];
  assign w_hdr_ok    = s_data[31]
                       && (w_hdr_col < 8'(NumColumns))
                       && (w_hdr_frame < 8'(MaxFramesPerCol));
  assign w_accept    = s_valid && r_ready;

  // NOTE: sequential state uses <= so every register samples its pre-edge inputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_load_hdr    = 1'b0;
    w_load_data   = 1'b0;
    w_hdr_err     = 1'b0;
    w_strobe_done = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_load_hdr   = 1'b1;
            w_next_state = ST_WAIT_DATA;
          end else begin
            w_hdr_err = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (w_accept) begin
          w_load_data  = 1'b1;
          w_next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_next_state = ST_STROBE;
      end
      ST_STROBE: begin
        if (r_cnt == LAST_STROBE) begin
          w_strobe_done = 1'b1;
          w_next_state  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_burst && (r_frame != LAST_FRAME)) begin
          w_advance    = 1'b1;
          w_next_state = ST_WAIT_DATA;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Strobe is decoded from the next state and registered, so the latch enables never glitch.
  always_comb begin
    w_strobe_idx  = IDX_W'(r_col) * IDX_W'(MaxFramesPerCol) + IDX_W'(r_frame);
    w_strobe_next = '0;
    if (w_next_state == ST_STROBE) begin
      w_strobe_next[w_strobe_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_col         <= '0;
      r_frame       <= '0;
      r_burst       <= 1'b0;
      r_cnt         <= '0;
      r_frame_data  <= '0;
      r_strobe      <= '0;
      r_ready       <= 1'b0;
      r_err         <= 1'b0;
      r_frames_done <= '0;
    end else begin
      r_strobe <= w_strobe_next;
      r_ready  <= (w_next_state == ST_IDLE) || (w_next_state == ST_WAIT_DATA);

      if (w_load_hdr) begin
        r_col   <= w_hdr_col[COL_W-1:0];
        r_frame <= w_hdr_frame[FRAME_W-1:0];
        r_burst <= s_data[30];
      end else if (w_advance) begin
        r_frame <= r_frame + FRAME_W'(1);
      end

      if (w_load_data) begin
        r_frame_data <= s_data[FrameBitsPerRow-1:0];
      end

      if (r_state == ST_STROBE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      if (w_hdr_err) begin
        r_err <= 1'b1;
      end

      if (w_strobe_done) begin
        r_frames_done <= r_frames_done + 16'd1;
      end
    end
  end

  assign s_ready     = r_ready;
  assign FrameData   = r_frame_data;
  assign FrameStrobe = r_strobe;
  assign busy        = (r_state != ST_IDLE);
  assign err         = r_err;
  assign frames_done = r_frames_done;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Testbench for frame_config_sequencer: scenario tasks push expected strobes to a scoreboard
// queue; a negedge monitor pops and checks each strobe pulse, its data and its length.
`timescale 1ns/1ps

module tb_frame_config_sequencer;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int NC = 4;
  localparam int SC = 2;
  localparam int NS = NC * MF;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FB-1:0] FrameData;
  logic [NS-1:0] FrameStrobe;
  logic          busy;
  logic          err;
  logic [15:0]   frames_done;

  frame_config_sequencer #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(MF),
    .NumColumns     (NC),
    .StrobeCycles   (SC)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .err        (err),
    .frames_done(frames_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_done = '0;

  // ---------------- strobe monitor / scoreboard consumer ----------------
  logic [NS-1:0] prev_strobe = '0;
  logic [FB-1:0] prev_data = '0;
  logic [NS-1:0] exp_vec;
  int            pulse_len = 0;

  always @(negedge CLK) begin
    if (!resetn) begin
      prev_strobe = '0;
      pulse_len   = 0;
    end else begin
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: FrameStrobe=%h with no frame pending", FrameStrobe);
        end else begin
          mon_e   = sb_q.pop_front();
          exp_vec = '0;
          exp_vec[mon_e.idx] = 1'b1;
          if (FrameStrobe !== exp_vec || FrameData !== mon_e.data || prev_data !== mon_e.data) begin
            n_fail++;
            $display("FAIL strobe_start: strobe=%h data=%h data_before=%h expected bit %0d data=%h",
                     FrameStrobe, FrameData, prev_data, mon_e.idx, mon_e.data);
          end
        end
        pulse_len = 1;
      end else if (FrameStrobe != '0) begin
        n_checks++;
        if (FrameStrobe !== prev_strobe) begin
          n_fail++;
          $display("FAIL strobe_stable: strobe=%h changed from %h mid-pulse", FrameStrobe, prev_strobe);
        end
        pulse_len++;
      end else if (prev_strobe != '0) begin
        exp_done = exp_done + 16'd1;
        n_checks++;
        if (pulse_len != SC || frames_done !== exp_done) begin
          n_fail++;
          $display("FAIL strobe_end: pulse_len=%0d frames_done=%h expected len=%0d frames_done=%h",
                   pulse_len, frames_done, SC, exp_done);
        end
        pulse_len = 0;
      end
      prev_strobe = FrameStrobe;
      prev_data   = FrameData;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_word(input logic [31:0] d);
    int t;
    @(negedge CLK);
    s_data  = d;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, t);
    end
    @(negedge CLK);
    s_valid = 1'b0;
    s_data  = $urandom();
  endtask

  task automatic send_data(input logic [31:0] d, input int idx);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb_q.push_back(e);
    send_word(d);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, t);
    end
  endtask

  task automatic cycles_to_ready(output int n);
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    resetn = 1'b0;
    @(negedge CLK);
    resetn   = 1'b1;
    exp_done = '0;
    sb_q.delete();
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    n_checks++;
    if (FrameStrobe !== '0 || FrameData !== '0 || frames_done !== '0) begin
      n_fail++;
      $display("FAIL reset_data: strobe=%h data=%h done=%h expected all 0", FrameStrobe, FrameData, frames_done);
    end
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b err=%b s_ready=%b expected 0 0 0", busy, err, s_ready);
    end
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b busy=%b expected 1 0", s_ready, busy);
    end
  endtask

  task automatic test_single();
    int n;
    send_word(32'h8002_0005);
    n_checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait_data: busy=%b s_ready=%b expected 1 1", busy, s_ready);
    end
    send_data(32'hDEAD_BEEF, 45);
    cycles_to_ready(n);
    n_checks++;
    if (n != SC + 2) begin
      n_fail++;
      $display("FAIL single_latency: ready after %0d cycles, expected %0d", n, SC + 2);
    end
    n_checks++;
    if (busy !== 1'b0 || frames_done !== 16'd1 || FrameData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_end: busy=%b done=%h data=%h expected 0 0001 deadbeef", busy, frames_done, FrameData);
    end
  endtask

  task automatic test_bad_header();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_hdr_pre: err=%b expected 0", err);
    end
    send_word(32'h8004_0000);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_hdr_col: err=%b busy=%b s_ready=%b expected 1 0 1", err, busy, s_ready);
    end
    send_word(32'h8000_0014);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_hdr_frame: err=%b busy=%b s_ready=%b expected 1 0 1", err, busy, s_ready);
    end
    send_word(32'h8000_0000);
    send_data(32'hA5A5_5A5A, 0);
    wait_idle();
    n_checks++;
    if (frames_done !== 16'd2 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_hdr_recover: done=%h err=%b expected 0002 1", frames_done, err);
    end
  endtask

  task automatic test_burst();
    send_word(32'hC001_0012);
    send_data(32'h1111_1111, 38);
    send_data(32'h2222_2222, 39);
    wait_idle();
    n_checks++;
    if (err !== 1'b0 || frames_done !== 16'd2) begin
      n_fail++;
      $display("FAIL burst_wrap: err=%b done=%h expected 0 0002", err, frames_done);
    end
    send_word(32'h3333_3333);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_third_word: err=%b busy=%b s_ready=%b expected 1 0 1", err, busy, s_ready);
    end
  endtask

  task automatic test_wait_data();
    int bad;
    int n;
    send_word(32'h8001_0003);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (FrameStrobe != '0 || busy !== 1'b1 || s_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_data_idle: %0d bad cycles, expected 0", bad);
    end
    send_data(32'hCAFE_F00D, 23);
    cycles_to_ready(n);
    n_checks++;
    if (n != SC + 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_data_latency: ready after %0d busy=%b, expected %0d 0", n, busy, SC + 2);
    end
  endtask

  task automatic test_wrap();
    wait_idle();
    @(negedge CLK);
    force dut.r_frames_done = 16'hFFFF;
    @(negedge CLK);
    release dut.r_frames_done;
    exp_done = 16'hFFFF;
    send_word(32'h8003_0013);
    send_data(32'h0F0F_0F0F, 79);
    wait_idle();
    n_checks++;
    if (frames_done !== 16'h0000) begin
      n_fail++;
      $display("FAIL done_wrap: frames_done=%h expected 0000", frames_done);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    send_word(32'h8000_0001);
    send_data(32'h1234_5678, 1);
    t = 0;
    while (FrameStrobe == '0 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    if (FrameStrobe == '0) begin
      n_fail++;
      $display("FAIL reset_mid_start: no strobe within %0d cycles", t);
    end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (FrameStrobe !== '0 || frames_done !== '0 || FrameData !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: strobe=%h done=%h data=%h busy=%b err=%b expected all 0",
               FrameStrobe, frames_done, FrameData, busy, err);
    end
    exp_done = '0;
    @(negedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    send_word(32'hC003_0011);
    send_data(32'h7777_0001, 77);
    send_data(32'h7777_0002, 78);
    send_data(32'h7777_0003, 79);
    wait_idle();
    n_checks++;
    if (busy !== 1'b0 || frames_done !== 16'd3 || FrameData !== 32'h7777_0003) begin
      n_fail++;
      $display("FAIL back_to_back: busy=%b done=%h data=%h expected 0 0003 77770003", busy, frames_done, FrameData);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_header();
    do_reset();
    test_burst();
    test_wait_data();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d strobes still pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
